// File: rtl/pdp8_bus_bridge.sv
// pdp8_bus_bridge
//   Decodes the PDP-8 core's multiplexed 8-bit io_out bus into a 12-bit
//   synchronous SRAM port and a handshaked 12-bit peripheral port, and
//   returns read nibbles plus busy/io_mode flags on the core's io_in[7:2].
// Ports:
//   clk, rst                 clock, async active-low reset
//   bus_out                  CPU io_out (ADDR / IO-SEL / DATA phases)
//   bus_din, bus_flags       read nibble and {io_mode, busy} back to the CPU
//   mem_*                    SRAM: registered addr, 1-cycle re/we pulses,
//                            rdata valid the cycle after mem_re
//   io_sel, io_rd, io_wr,    peripheral request, held until io_ack or
//   io_wdata, io_rdata,      TIMEOUT cycles elapse; io_timeout flags an
//   io_ack, io_timeout       aborted transaction
module pdp8_bus_bridge #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TW      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  bus_out,
   output logic [3:0]  bus_din,
   output logic [1:0]  bus_flags,
   output logic [11:0] mem_addr,
   output logic        mem_re,
   output logic        mem_we,
   output logic [11:0] mem_wdata,
   input  logic [11:0] mem_rdata,
   output logic [4:0]  io_sel,
   output logic        io_rd,
   output logic        io_wr,
   output logic [11:0] io_wdata,
   input  logic [11:0] io_rdata,
   input  logic        io_ack,
   output logic        io_timeout
);

   typedef enum logic [1:0] {IO_IDLE, IO_RD, IO_WR} io_st_e;

   io_st_e          st_q, st_d;
   logic [TW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [11:0]     addr_q, addr_d, rbuf_q, rbuf_d, io_rbuf_q, io_rbuf_d;
   logic [11:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [11:0]     io_wdata_q, io_wdata_d;
   logic [7:0]      tmp_q, tmp_d;
   logic [4:0]      io_sel_q, io_sel_d;
   logic            io_mode_q, io_mode_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
   logic            rd_wait_q, rd_wait_d, io_rd_q, io_rd_d, io_wr_q, io_wr_d;
   logic            io_timeout_q, io_timeout_d, busy_q, busy_d;

   // phase decode; every bus value falls into exactly one phase
   logic        addr_ph, iosel_ph, data_ph, wr_stb, commit, commit_mem, commit_io;
   logic [3:0]  nib;
   logic [11:0] word, src;

   assign addr_ph    = bus_out[7];
   assign iosel_ph   = (bus_out[7:5] == 3'b011);
   assign data_ph    = !bus_out[7] && (bus_out[6:5] != 2'b11);
   assign wr_stb     = data_ph && !bus_out[4];
   assign nib        = bus_out[3:0];
   assign commit     = wr_stb && (bus_out[6:5] == 2'b10);
   assign word       = {tmp_q, nib};
   assign commit_mem = commit && !io_mode_q;
   assign commit_io  = commit && io_mode_q && (st_q == IO_IDLE);
   assign cnt_inc    = cnt_q + 1'b1;

   always_comb begin
      addr_d       = addr_q;
      tmp_d        = tmp_q;
      rbuf_d       = rbuf_q;
      io_rbuf_d    = io_rbuf_q;
      io_sel_d     = io_sel_q;
      io_wdata_d   = io_wdata_q;
      mem_wdata_d  = mem_wdata_q;
      io_mode_d    = io_mode_q;
      io_timeout_d = io_timeout_q;
      st_d         = st_q;
      cnt_d        = cnt_q;

      if (addr_ph) begin
         if (bus_out[6]) addr_d[11:6] = bus_out[5:0];
         else            addr_d[5:0]  = bus_out[5:0];
         io_mode_d = 1'b0;
      end

      if (wr_stb && bus_out[6:5] == 2'b00) tmp_d[7:4] = nib;
      if (wr_stb && bus_out[6:5] == 2'b01) tmp_d[3:0] = nib;

      // ADDR and DATA phases are mutually exclusive on the bus, so a read
      // request and a write commit can never land in the same cycle and
      // mem_re/mem_we never collide.
      mem_re_d   = addr_ph;
      mem_we_d   = commit_mem;
      mem_addr_d = addr_d;
      if (commit_mem) mem_wdata_d = word;

      // A commit cancels any in-flight read (always of the same address,
      // since addr only moves on ADDR phases); a new ADDR restarts it.
      rd_wait_d = mem_re_q && !addr_ph && !commit_mem;
      if (commit_mem)     rbuf_d = word;
      else if (rd_wait_q) rbuf_d = mem_rdata;

      case (st_q)
         IO_IDLE: begin
            if (iosel_ph) begin
               io_sel_d     = bus_out[4:0];
               io_mode_d    = 1'b1;
               io_timeout_d = 1'b0;
               cnt_d        = '0;
               st_d         = IO_RD;
            end else if (commit_io) begin
               io_wdata_d   = word;
               io_timeout_d = 1'b0;
               cnt_d        = '0;
               st_d         = IO_WR;
            end
         end
         IO_RD, IO_WR: begin
            cnt_d = cnt_inc;
            if (io_ack) begin
               if (st_q == IO_RD) io_rbuf_d = io_rdata;
               st_d = IO_IDLE;
            end else if (cnt_inc == TW'(TIMEOUT)) begin
               if (st_q == IO_RD) io_rbuf_d = 12'hFFF;
               io_timeout_d = 1'b1;
               st_d         = IO_IDLE;
            end
         end
         default: st_d = IO_IDLE;
      endcase

      io_rd_d = (st_d == IO_RD);
      io_wr_d = (st_d == IO_WR);
      busy_d  = mem_re_d || rd_wait_d || (st_d != IO_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q         <= IO_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         tmp_q        <= '0;
         rbuf_q       <= '0;
         io_rbuf_q    <= '0;
         io_sel_q     <= '0;
         io_wdata_q   <= '0;
         mem_wdata_q  <= '0;
         mem_addr_q   <= '0;
         io_mode_q    <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         rd_wait_q    <= 1'b0;
         io_rd_q      <= 1'b0;
         io_wr_q      <= 1'b0;
         io_timeout_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         st_q         <= st_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         tmp_q        <= tmp_d;
         rbuf_q       <= rbuf_d;
         io_rbuf_q    <= io_rbuf_d;
         io_sel_q     <= io_sel_d;
         io_wdata_q   <= io_wdata_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_addr_q   <= mem_addr_d;
         io_mode_q    <= io_mode_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         rd_wait_q    <= rd_wait_d;
         io_rd_q      <= io_rd_d;
         io_wr_q      <= io_wr_d;
         io_timeout_q <= io_timeout_d;
         busy_q       <= busy_d;
      end
   end

   // read nibble mux stays combinational so the CPU sees it in the same cycle
   assign src = io_mode_q ? io_rbuf_q : rbuf_q;
   always_comb begin
      case (bus_out[6:5])
         2'b00:   bus_din = src[11:8];
         2'b01:   bus_din = src[7:4];
         2'b10:   bus_din = src[3:0];
         default: bus_din = 4'h0;
      endcase
   end

   assign bus_flags  = {io_mode_q, busy_q};
   assign mem_addr   = mem_addr_q;
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
   assign io_sel     = io_sel_q;
   assign io_rd      = io_rd_q;
   assign io_wr      = io_wr_q;
   assign io_wdata   = io_wdata_q;
   assign io_timeout = io_timeout_q;

endmodule
